// File: rtl/wb_queue.sv
// wb_queue: write-back buffer in front of the 16 x 16-bit register file write port.
// Results are accepted on a valid/ready handshake and buffered in a DEPTH-entry FIFO.
// One entry per cycle is drained into the register file (rf_we/rf_rd/rf_data).
// Optional feature macro: WB_BYPASS_EN adds a combinational lookup of queued results
// so that operand fetch can see values that have not reached the register file yet.
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_rd,
  input  logic [15:0]   in_data,
  input  logic          rf_stall,
  output logic          rf_we,
  output logic [3:0]    rf_rd,
  output logic [15:0]   rf_data,
  output logic [AW:0]   count
`ifdef WB_BYPASS_EN
  ,
  input  logic [3:0]    byp_rs,
  input  logic [3:0]    byp_rt,
  output logic          byp_hit_a,
  output logic          byp_hit_b,
  output logic [15:0]   byp_a,
  output logic [15:0]   byp_b
`endif
);

  // Entry storage; contents are never reset, occupancy is tracked by r_count
  logic [3:0]  r_rd_mem   [DEPTH];
  logic [15:0] r_data_mem [DEPTH];

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_accept;
  logic w_drain;

  // Full when every entry is occupied; no pass-through while full
  assign in_ready = (r_count != (AW+1)'(DEPTH));
  assign rf_we    = (r_count != '0) && !rf_stall;
  assign rf_rd    = r_rd_mem[r_rd_ptr];
  assign rf_data  = r_data_mem[r_rd_ptr];
  assign count    = r_count;

  assign w_accept = in_valid && in_ready;
  assign w_drain  = rf_we;

  // Write the accepted result into the tail slot
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_rd_mem[r_wr_ptr]   <= in_rd;
      r_data_mem[r_wr_ptr] <= in_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_drain) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_accept, w_drain})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef WB_BYPASS_EN
  // Walk occupied entries oldest to newest so the newest match overrides older ones;
  // the entry being accepted this cycle is not yet counted, so it stays invisible
  always_comb begin
    logic [AW-1:0] v_idx;
    v_idx     = '0;
    byp_hit_a = 1'b0;
    byp_hit_b = 1'b0;
    byp_a     = 16'h0000;
    byp_b     = 16'h0000;
    for (int k = 0; k < DEPTH; k++) begin
      v_idx = r_rd_ptr + AW'(k);
      if ((AW+1)'(k) < r_count) begin
        if (r_rd_mem[v_idx] == byp_rs) begin
          byp_hit_a = 1'b1;
          byp_a     = r_data_mem[v_idx];
        end
        if (r_rd_mem[v_idx] == byp_rt) begin
          byp_hit_b = 1'b1;
          byp_b     = r_data_mem[v_idx];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: table vectors, hand-written corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_wb_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_rd = 4'h0;
  logic [15:0] in_data = 16'h0;
  logic        rf_stall = 1'b0;
  logic        rf_we;
  logic [3:0]  rf_rd;
  logic [15:0] rf_data;
  logic [AW:0] count;
`ifdef WB_BYPASS_EN
  logic [3:0]  byp_rs = 4'h0;
  logic [3:0]  byp_rt = 4'h0;
  logic        byp_hit_a;
  logic        byp_hit_b;
  logic [15:0] byp_a;
  logic [15:0] byp_b;
`endif

  wb_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
    .rf_stall(rf_stall), .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data),
    .count(count)
`ifdef WB_BYPASS_EN
    , .byp_rs(byp_rs), .byp_rt(byp_rt), .byp_hit_a(byp_hit_a), .byp_hit_b(byp_hit_b),
    .byp_a(byp_a), .byp_b(byp_b)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge, then let them settle before checking
  task automatic drive(input logic v, input logic [3:0] rd, input logic [15:0] d, input logic st);
    @(posedge clk);
    #1;
    in_valid = v;
    in_rd    = rd;
    in_data  = d;
    rf_stall = st;
    #1;
  endtask

  typedef struct {
    logic        valid;
    logic [3:0]  rd;
    logic [15:0] data;
    logic        stall;
    logic        exp_we;
    logic [3:0]  exp_rd;
    logic [15:0] exp_data;
    logic [2:0]  exp_count;
    logic        exp_ready;
  } vec_t;

  typedef struct {
    logic [3:0]  rd;
    logic [15:0] data;
  } ent_t;

  vec_t vecs[14];
  ent_t model[$];

  initial begin
    // Single push latency, then stall-fill with a held 5th entry and ordered release
    vecs[0]  = '{1'b1, 4'h2, 16'hAAAA, 1'b0, 1'b0, 4'h0, 16'h0000, 3'd0, 1'b1};
    vecs[1]  = '{1'b0, 4'h0, 16'h0000, 1'b0, 1'b1, 4'h2, 16'hAAAA, 3'd1, 1'b1};
    vecs[2]  = '{1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 4'h0, 16'h0000, 3'd0, 1'b1};
    vecs[3]  = '{1'b1, 4'h1, 16'h0101, 1'b1, 1'b0, 4'h0, 16'h0000, 3'd0, 1'b1};
    vecs[4]  = '{1'b1, 4'h2, 16'h0202, 1'b1, 1'b0, 4'h0, 16'h0000, 3'd1, 1'b1};
    vecs[5]  = '{1'b1, 4'h3, 16'h0303, 1'b1, 1'b0, 4'h0, 16'h0000, 3'd2, 1'b1};
    vecs[6]  = '{1'b1, 4'h4, 16'h0404, 1'b1, 1'b0, 4'h0, 16'h0000, 3'd3, 1'b1};
    vecs[7]  = '{1'b1, 4'h5, 16'h0505, 1'b1, 1'b0, 4'h0, 16'h0000, 3'd4, 1'b0};
    vecs[8]  = '{1'b1, 4'h5, 16'h0505, 1'b0, 1'b1, 4'h1, 16'h0101, 3'd4, 1'b0};
    vecs[9]  = '{1'b1, 4'h5, 16'h0505, 1'b0, 1'b1, 4'h2, 16'h0202, 3'd3, 1'b1};
    vecs[10] = '{1'b0, 4'h0, 16'h0000, 1'b0, 1'b1, 4'h3, 16'h0303, 3'd3, 1'b1};
    vecs[11] = '{1'b0, 4'h0, 16'h0000, 1'b0, 1'b1, 4'h4, 16'h0404, 3'd2, 1'b1};
    vecs[12] = '{1'b0, 4'h0, 16'h0000, 1'b0, 1'b1, 4'h5, 16'h0505, 3'd1, 1'b1};
    vecs[13] = '{1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 4'h0, 16'h0000, 3'd0, 1'b1};

    // Reset state
    #2;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_we", 32'(rf_we), 32'd0);
    chk("reset_ready", 32'(in_ready), 32'd1);
`ifdef WB_BYPASS_EN
    chk("reset_hit_a", 32'(byp_hit_a), 32'd0);
    chk("reset_hit_b", 32'(byp_hit_b), 32'd0);
`endif
    #10 rst_n = 1'b1;

    // Table vectors
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].valid, vecs[i].rd, vecs[i].data, vecs[i].stall);
      $display("vec %0d: we=%0b rd=%0h data=%0h count=%0d ready=%0b", i, rf_we, rf_rd, rf_data, count, in_ready);
      chk($sformatf("vec%0d_we", i), 32'(rf_we), 32'(vecs[i].exp_we));
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      chk($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(vecs[i].exp_ready));
      if (vecs[i].exp_we) begin
        chk($sformatf("vec%0d_rd", i), 32'(rf_rd), 32'(vecs[i].exp_rd));
        chk($sformatf("vec%0d_data", i), 32'(rf_data), 32'(vecs[i].exp_data));
      end
    end

    // Continuous push and drain: count stays 1 while pointers wrap repeatedly
    drive(1'b1, 4'h0, 16'h1000, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      drive(1'b1, 4'(k), 16'h1000 + 16'(k), 1'b0);
      $display("stream %0d: we=%0b rd=%0h data=%0h count=%0d", k, rf_we, rf_rd, rf_data, count);
      chk("stream_count", 32'(count), 32'd1);
      chk("stream_we", 32'(rf_we), 32'd1);
      chk("stream_rd", 32'(rf_rd), 32'(k - 1));
      chk("stream_data", 32'(rf_data), 32'h1000 + 32'(k - 1));
    end
    drive(1'b0, 4'h0, 16'h0, 1'b0);
    chk("stream_last_data", 32'(rf_data), 32'h100A);
    drive(1'b0, 4'h0, 16'h0, 1'b0);
    chk("stream_empty", 32'(count), 32'd0);

    // Asynchronous reset between edges with three entries queued
    drive(1'b1, 4'h6, 16'h6661, 1'b1);
    drive(1'b1, 4'h6, 16'h6662, 1'b1);
    drive(1'b1, 4'h6, 16'h6663, 1'b1);
    drive(1'b0, 4'h0, 16'h0, 1'b0);
    chk("prerst_count", 32'(count), 32'd3);
    chk("prerst_we", 32'(rf_we), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    $display("async reset: we=%0b count=%0d ready=%0b", rf_we, count, in_ready);
    chk("arst_we", 32'(rf_we), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 4'h0, 16'h0, 1'b0);
      chk("postrst_we", 32'(rf_we), 32'd0);
      chk("postrst_count", 32'(count), 32'd0);
    end

    // Accept and drain in the same cycle with two entries queued
    drive(1'b1, 4'h7, 16'h7777, 1'b1);
    drive(1'b1, 4'h8, 16'h8888, 1'b1);
    drive(1'b1, 4'h9, 16'h9999, 1'b0);
    chk("ad_count_before", 32'(count), 32'd2);
    chk("ad_we", 32'(rf_we), 32'd1);
    chk("ad_rd", 32'(rf_rd), 32'h7);
    drive(1'b0, 4'h0, 16'h0, 1'b1);
    chk("ad_count_after", 32'(count), 32'd2);
    chk("ad_head_rd", 32'(rf_rd), 32'h8);
    chk("ad_head_data", 32'(rf_data), 32'h8888);
    drive(1'b0, 4'h0, 16'h0, 1'b0);
    chk("ad_drain8", 32'(rf_data), 32'h8888);
    drive(1'b0, 4'h0, 16'h0, 1'b0);
    chk("ad_tail_rd", 32'(rf_rd), 32'h9);
    chk("ad_tail_data", 32'(rf_data), 32'h9999);
    chk("ad_tail_count", 32'(count), 32'd1);
    drive(1'b0, 4'h0, 16'h0, 1'b0);
    chk("ad_empty", 32'(count), 32'd0);

`ifdef WB_BYPASS_EN
    // Bypass: newest match wins, same-cycle accept invisible, draining head still visible
    byp_rs = 4'h3;
    byp_rt = 4'h5;
    drive(1'b1, 4'h3, 16'h1111, 1'b1);
    chk("byp_empty_hit", 32'(byp_hit_a), 32'd0);
    drive(1'b1, 4'h3, 16'h2222, 1'b1);
    chk("byp_old_hit", 32'(byp_hit_a), 32'd1);
    chk("byp_old_data", 32'(byp_a), 32'h1111);
    drive(1'b0, 4'h0, 16'h0, 1'b1);
    $display("bypass: hit_a=%0b a=%0h hit_b=%0b b=%0h", byp_hit_a, byp_a, byp_hit_b, byp_b);
    chk("byp_new_hit", 32'(byp_hit_a), 32'd1);
    chk("byp_new_data", 32'(byp_a), 32'h2222);
    chk("byp_miss_hit", 32'(byp_hit_b), 32'd0);
    chk("byp_miss_data", 32'(byp_b), 32'h0);
    drive(1'b0, 4'h0, 16'h0, 1'b0);
    chk("byp_drain1_data", 32'(byp_a), 32'h2222);
    drive(1'b0, 4'h0, 16'h0, 1'b0);
    chk("byp_head_hit", 32'(byp_hit_a), 32'd1);
    chk("byp_head_data", 32'(byp_a), 32'h2222);
    drive(1'b0, 4'h0, 16'h0, 1'b0);
    chk("byp_gone", 32'(byp_hit_a), 32'd0);
`endif

    // Randomized traffic against the queue reference model (queue is empty here)
    model.delete();
    for (int c = 0; c < 400; c++) begin
      logic        exp_we;
      logic        acc;
      logic [3:0]  rd_r;
      logic [15:0] d_r;
      rd_r = 4'($urandom_range(0, 15));
      d_r  = 16'($urandom);
      drive(($urandom_range(0, 3) != 0), rd_r, d_r, ($urandom_range(0, 1) == 1));
`ifdef WB_BYPASS_EN
      byp_rs = 4'($urandom_range(0, 15));
      byp_rt = 4'($urandom_range(0, 15));
      #1;
`endif
      exp_we = (model.size() != 0) && !rf_stall;
      acc    = in_valid && (model.size() < DEPTH);
      $display("rand %0d: v=%0b rd=%0h d=%0h st=%0b we=%0b count=%0d", c, in_valid, in_rd, in_data, rf_stall, rf_we, count);
      chk("rand_count", 32'(count), 32'(model.size()));
      chk("rand_ready", 32'(in_ready), 32'(model.size() < DEPTH));
      chk("rand_we", 32'(rf_we), 32'(exp_we));
      if (exp_we) begin
        chk("rand_rd", 32'(rf_rd), 32'(model[0].rd));
        chk("rand_data", 32'(rf_data), 32'(model[0].data));
      end
`ifdef WB_BYPASS_EN
      begin
        logic hit_a, hit_b;
        logic [15:0] ea, eb;
        hit_a = 1'b0; hit_b = 1'b0; ea = 16'h0; eb = 16'h0;
        for (int j = model.size() - 1; j >= 0; j--) begin
          if (!hit_a && model[j].rd == byp_rs) begin hit_a = 1'b1; ea = model[j].data; end
          if (!hit_b && model[j].rd == byp_rt) begin hit_b = 1'b1; eb = model[j].data; end
        end
        chk("rand_hit_a", 32'(byp_hit_a), 32'(hit_a));
        chk("rand_byp_a", 32'(byp_a), 32'(ea));
        chk("rand_hit_b", 32'(byp_hit_b), 32'(hit_b));
        chk("rand_byp_b", 32'(byp_b), 32'(eb));
      end
`endif
      if (exp_we) void'(model.pop_front());
      if (acc) model.push_back('{in_rd, in_data});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_queue.md
Name: wb_queue

Overview:
- Write-back buffer that is the writer side of the 16-register x 16-bit register file write port (rd, data_in).
- Accepts ALU/load results over a valid/ready handshake and buffers them in a small FIFO.
- Drains one entry per cycle into the register file as rf_we / rf_rd / rf_data.
- Sits between the execute stage and the regfile; the optional bypass lets operand fetch see results that are still queued.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- AW, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  a result is offered.
- in_ready  output  1  the queue can accept a result this cycle.
- in_rd  input  4  destination register index.
- in_data  input  16  result value.
- rf_stall  input  1  the register file write port is unavailable this cycle.
- rf_we  output  1  register file write enable.
- rf_rd  output  4  register file write index (maps to regfile rd).
- rf_data  output  16  register file write data (maps to regfile data_in).
- count  output  AW+1  number of occupied entries.
- byp_rs  input  4  bypass lookup index A (WB_BYPASS_EN only).
- byp_rt  input  4  bypass lookup index B (WB_BYPASS_EN only).
- byp_hit_a  output  1  byp_rs matches a queued entry (WB_BYPASS_EN only).
- byp_hit_b  output  1  byp_rt matches a queued entry (WB_BYPASS_EN only).
- byp_a  output  16  data for byp_rs (WB_BYPASS_EN only).
- byp_b  output  16  data for byp_rt (WB_BYPASS_EN only).

Behaviour:
- Reset, asynchronous while rst_n=0: wr_ptr=0, rd_ptr=0, count=0, rf_we=0, in_ready=1, byp_hit_a=byp_hit_b=0. Entry storage contents are don't-care.
- Reset asserted mid-operation discards all queued entries immediately; no write is issued after reset.
- Accept: an entry is written at wr_ptr on a clock edge where in_valid && in_ready; wr_ptr then increments, wrapping DEPTH-1 to 0.
- in_ready = (count != DEPTH), combinational from registered count. There is no pass-through when full.
- Drain: rf_we = (count != 0) && !rf_stall, combinational. rf_rd and rf_data always show the head entry at rd_ptr.
- The register file commits on the same edge. rd_ptr increments on an edge where rf_we=1, wrapping the same way.
- rf_rd and rf_data are undefined when count=0; the bench must ignore them while rf_we=0.
- Latency: an accepted result appears on rf_we/rf_rd/rf_data in the next cycle (1 cycle) if the queue was empty and rf_stall=0.
- count next = count + accept - drain.
  - Simultaneous accept and drain leaves count unchanged.
  - Accept while empty is legal in the same cycle rf_we=0 (nothing to drain).
  - Accept is impossible while full.
- Order: strictly FIFO. Two queued writes to the same rd are both issued in order, so the last one wins in the regfile.
- rf_stall held high: the head is retained, count holds, and the queue fills to DEPTH, then in_ready=0.
- rd=0 receives no special treatment; it is written like any other register.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined:
  - Combinational search of all occupied entries for byp_rs and byp_rt.
  - On multiple matches, the newest entry (closest to wr_ptr) wins.
  - The head entry being drained this cycle counts as occupied.
  - The entry being accepted this cycle is not visible until the next cycle.
  - On a miss, hit=0 and data=16'h0000.
- Not defined: the byp_* ports are absent, and no compare logic is generated.

Test Plan:
- Reset, then one push rd=4'h2, data=16'hAAAA -> next cycle rf_we=1, rf_rd=2, rf_data=16'hAAAA; the following cycle rf_we=0 and count=0.
- rf_stall=1 while pushing 5 entries with DEPTH=4 -> count=4 and in_ready=0 after the 4th accept; the 5th is held. Release stall -> writes issue for 4 consecutive cycles in push order, then the 5th.
- Continuous push and drain, one per cycle for 10 cycles -> count stays 1, and the wr_ptr/rd_ptr wrap is exercised with no loss or duplication.
- Push rd=3 with 16'h1111, then rd=3 with 16'h2222, with rf_stall=1; byp_rs=3 -> byp_hit_a=1, byp_a=16'h2222 (WB_BYPASS_EN). byp_rt=5 -> byp_hit_b=0, byp_b=0.
- Assert rst_n=0 asynchronously between edges with count=3 -> rf_we, count and in_ready update immediately to 0, 0 and 1. After release, no stale writes appear.
- Accept and drain in the same cycle with count=2 -> count stays 2, the head advances, and the new entry lands at the tail.
